// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one backing-memory burst port between the
// I-cache and D-cache controllers, sequencing line bursts beat by beat.
module cache_mem_arbiter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          iCLK,
    input  logic                          iRSTn,
    input  logic                          iIReq,
    input  logic [31:0]                   iIADDR,
    output logic                          oIGnt,
    output logic [31:0]                   oIDATA,
    output logic                          oIValid,
    output logic [$clog2(LINE_WORDS)-1:0] oIBeat,
    output logic                          oIDone,
    input  logic                          iDReq,
    input  logic                          iDWE,
    input  logic [31:0]                   iDADDR,
    input  logic [31:0]                   iDWDATA,
    output logic                          oDGnt,
    output logic [31:0]                   oDDATA,
    output logic                          oDValid,
    output logic [$clog2(LINE_WORDS)-1:0] oDBeat,
    output logic                          oDDone,
    output logic                          oMemREQ,
    output logic                          oMemWE,
    output logic [31:0]                   oMemADDR,
    output logic [31:0]                   oMemWDATA,
    input  logic [31:0]                   iMemRDATA,
    input  logic                          iMemVALID
);

    localparam int unsigned CNT_W  = $clog2(LINE_WORDS);
    localparam int unsigned BASE_W = 30 - CNT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BURST_I, BURST_D} state_t;

    state_t            state;
    logic [BASE_W-1:0] base;
    logic [CNT_W-1:0]  beat;
    logic              lastGntD;
    logic              dWe;
    logic              unusedAddrBits;

    // Byte/word offset bits inside a line carry no meaning for a line burst.
    assign unusedAddrBits = ^{iIADDR[CNT_W+1:0], iDADDR[CNT_W+1:0]};

    assign oMemADDR  = oMemREQ ? {base, beat, 2'b00} : 32'h0;
    assign oMemWDATA = (state == BURST_D && dWe) ? iDWDATA : 32'h0;

    // A done pulse marks the cycle after a burst; arbitration waits one more IDLE cycle.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state    <= IDLE;
            base     <= '0;
            beat     <= '0;
            lastGntD <= 1'b1;
            dWe      <= 1'b0;
            oIGnt    <= 1'b0;
            oIDATA   <= '0;
            oIValid  <= 1'b0;
            oIBeat   <= '0;
            oIDone   <= 1'b0;
            oDGnt    <= 1'b0;
            oDDATA   <= '0;
            oDValid  <= 1'b0;
            oDBeat   <= '0;
            oDDone   <= 1'b0;
            oMemREQ  <= 1'b0;
            oMemWE   <= 1'b0;
        end else begin
            oIValid <= 1'b0;
            oDValid <= 1'b0;
            oIDone  <= 1'b0;
            oDDone  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!(oIDone || oDDone)) begin
                        if (iIReq && (!iDReq || lastGntD)) begin
                            state    <= BURST_I;
                            base     <= iIADDR[31:CNT_W+2];
                            beat     <= '0;
                            oIGnt    <= 1'b1;
                            oMemREQ  <= 1'b1;
                            oMemWE   <= 1'b0;
                            lastGntD <= 1'b0;
                        end else if (iDReq) begin
                            state    <= BURST_D;
                            base     <= iDADDR[31:CNT_W+2];
                            beat     <= '0;
                            dWe      <= iDWE;
                            oDGnt    <= 1'b1;
                            oDBeat   <= '0;
                            oMemREQ  <= 1'b1;
                            oMemWE   <= iDWE;
                            lastGntD <= 1'b1;
                        end
                    end
                end
                BURST_I: begin
                    if (iMemVALID) begin
                        oIDATA  <= iMemRDATA;
                        oIValid <= 1'b1;
                        oIBeat  <= beat;
                        if (beat == LAST_BEAT) begin
                            state   <= IDLE;
                            beat    <= '0;
                            oIDone  <= 1'b1;
                            oIGnt   <= 1'b0;
                            oMemREQ <= 1'b0;
                        end else begin
                            beat <= beat + CNT_W'(1);
                        end
                    end
                end
                BURST_D: begin
                    if (iMemVALID) begin
                        // Write beats expose the next index so the D-cache can present its word.
                        if (dWe) begin
                            oDBeat <= beat + CNT_W'(1);
                        end else begin
                            oDDATA  <= iMemRDATA;
                            oDValid <= 1'b1;
                            oDBeat  <= beat;
                        end
                        if (beat == LAST_BEAT) begin
                            state   <= IDLE;
                            beat    <= '0;
                            dWe     <= 1'b0;
                            oDDone  <= 1'b1;
                            oDGnt   <= 1'b0;
                            oMemREQ <= 1'b0;
                            oMemWE  <= 1'b0;
                        end else begin
                            beat <= beat + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
